attack_resolver: RTL and testbench

Per-turn attack generator that sits directly upstream of the turn/health state machine. It charges a shot while the active player holds fire and times the projectile's flight. It then scores the hit against the target distance and delivers `harm_by_1`/`harm_by_2` with a one-cycle `end_set_1`/`end_set_2` pulse for the game-state block to consume. It also drives the charge and flight indications used by the HUD/sprite logic.

---
 rtl/game_pkg.sv | 24 ++
 rtl/flight_timer.sv | 35 +++
 rtl/attack_resolver.sv | 151 +++++++++++++++
 tb/tb_attack_resolver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - turn encodings, resolver states and harm width shared by the attack logic
package game_pkg;

    localparam logic [1:0] TURN_NONE = 2'b00;
    localparam logic [1:0] TURN_P1   = 2'b01;
    localparam logic [1:0] TURN_P2   = 2'b10;

    localparam int HARM_W   = 9;
    localparam int HARM_MAX = (1 << HARM_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_FLIGHT,
        ST_RESOLVE,
        ST_DONE,
        ST_WAIT_TURN
    } resolver_state_t;

    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/flight_timer.sv
// rtl/flight_timer.sv - loadable down-counter timing the projectile flight; last flags count == 1
module flight_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/attack_resolver.sv
// rtl/attack_resolver.sv - charge/flight/resolve sequencer producing per-player harm; ATTACK_CRIT_EN doubles exact hits
module attack_resolver
    import game_pkg::*;
#(
    parameter int CHARGE_MAX = 255,
    parameter int HIT_WINDOW = 16,
    parameter int BASE_HARM  = 10
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic              fire,
    input  logic [1:0]        game_turn,
    input  logic [7:0]        target_dist,
    output logic [HARM_W-1:0] harm_by_1,
    output logic [HARM_W-1:0] harm_by_2,
    output logic              end_set_1,
    output logic              end_set_2,
    output logic [7:0]        charge_level,
    output logic              in_flight
);

    resolver_state_t   state_q, state_d;
    logic [1:0]        shooter_q, shooter_d;
    logic [7:0]        charge_q, charge_d;
    logic [HARM_W-1:0] harm1_q, harm1_d;
    logic [HARM_W-1:0] harm2_q, harm2_d;

    logic              flight_load;
    logic              flight_last;
    logic              turn_lost;
    int                diff_i;
    int                harm_i;
    logic [HARM_W-1:0] harm_val;

    flight_timer #(.W(8)) u_flight_timer (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .load  (flight_load),
        .en    (state_q == ST_FLIGHT),
        .value ({2'b00, charge_q[7:2]} + 8'd1),
        .last  (flight_last)
    );

    // Score computed at full integer width so the 9-bit result can saturate cleanly.
    always_comb begin
        diff_i = int'(abs_diff(charge_q, target_dist));
        harm_i = 0;
        if (diff_i <= HIT_WINDOW) begin
            harm_i = BASE_HARM + 2 * (HIT_WINDOW - diff_i);
        end
`ifdef ATTACK_CRIT_EN
        if (diff_i == 0) begin
            harm_i = 2 * harm_i;
        end
`endif
        if (harm_i > HARM_MAX) begin
            harm_val = HARM_W'(HARM_MAX);
        end else if (harm_i < 0) begin
            harm_val = '0;
        end else begin
            harm_val = HARM_W'(harm_i);
        end
    end

    assign turn_lost = (game_turn != shooter_q);

    always_comb begin
        state_d     = state_q;
        shooter_d   = shooter_q;
        charge_d    = charge_q;
        harm1_d     = harm1_q;
        harm2_d     = harm2_q;
        flight_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire && ((game_turn == TURN_P1) || (game_turn == TURN_P2))) begin
                    state_d   = ST_CHARGE;
                    shooter_d = game_turn;
                    charge_d  = 8'd0;
                end
            end
            ST_CHARGE: begin
                if (turn_lost) begin
                    state_d = ST_IDLE;
                end else if (fire) begin
                    if (charge_q < 8'(CHARGE_MAX)) begin
                        charge_d = charge_q + 8'd1;
                    end
                end else begin
                    state_d     = ST_FLIGHT;
                    flight_load = 1'b1;
                end
            end
            ST_FLIGHT: begin
                if (turn_lost) begin
                    state_d = ST_IDLE;
                end else if (flight_last) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (turn_lost) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (shooter_q == TURN_P1) begin
                        harm1_d = harm_val;
                    end else begin
                        harm2_d = harm_val;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_TURN;
            end
            ST_WAIT_TURN: begin
                // Hold off re-fire until the game-state block has handed the turn on.
                if (turn_lost) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            shooter_q <= TURN_NONE;
            charge_q  <= 8'd0;
            harm1_q   <= '0;
            harm2_q   <= '0;
        end else begin
            state_q   <= state_d;
            shooter_q <= shooter_d;
            charge_q  <= charge_d;
            harm1_q   <= harm1_d;
            harm2_q   <= harm2_d;
        end
    end

    assign harm_by_1    = harm1_q;
    assign harm_by_2    = harm2_q;
    assign end_set_1    = (state_q == ST_DONE) && (shooter_q == TURN_P1);
    assign end_set_2    = (state_q == ST_DONE) && (shooter_q == TURN_P2);
    assign charge_level = charge_q;
    assign in_flight    = (state_q == ST_FLIGHT);

endmodule

// File: tb/tb_attack_resolver.sv
// tb/tb_attack_resolver.sv - randomized self-checking bench for attack_resolver against a score/timing model
module tb_attack_resolver;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       fire      = 1'b0;
    logic [1:0] game_turn = 2'b00;
    logic [7:0] target_dist = 8'd0;
    logic [8:0] harm_by_1, harm_by_2;
    logic       end_set_1, end_set_2;
    logic [7:0] charge_level;
    logic       in_flight;

    int vectors = 0;
    int miscompares = 0;
    int exp_h1 = 0;
    int exp_h2 = 0;

    attack_resolver dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .fire         (fire),
        .game_turn    (game_turn),
        .target_dist  (target_dist),
        .harm_by_1    (harm_by_1),
        .harm_by_2    (harm_by_2),
        .end_set_1    (end_set_1),
        .end_set_2    (end_set_2),
        .charge_level (charge_level),
        .in_flight    (in_flight)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int model_harm(input int c, input int t);
        int d;
        int h;
        d = (c > t) ? c - t : t - c;
        if (d > 16) return 0;
        h = 10 + 2 * (16 - d);
`ifdef ATTACK_CRIT_EN
        if (d == 0) h = h * 2;
`endif
        if (h > 511) h = 511;
        return h;
    endfunction

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic end_turn();
        fire = 1'b0;
        game_turn = 2'b00;
        step();
        step();
    endtask

    // Drives one full shot and records what the DUT showed; tests judge the results.
    task automatic run_shot(input logic [1:0] turn, input int hold, input int target,
                            output int chg, output int flight_n, output int pulse_k,
                            output int n1, output int n2, output int both,
                            output int h1_at, output int h2_at);
        game_turn = turn;
        target_dist = target[7:0];
        fire = 1'b1;
        repeat (hold + 1) step();
        chg = int'(charge_level);
        fire = 1'b0;
        step();
        flight_n = 0; pulse_k = -1; n1 = 0; n2 = 0; both = 0; h1_at = -1; h2_at = -1;
        for (int k = 0; k < 90; k++) begin
            if (in_flight) flight_n++;
            if (end_set_1 && end_set_2) both++;
            if (end_set_1) n1++;
            if (end_set_2) n2++;
            if ((end_set_1 || end_set_2) && pulse_k < 0) begin
                pulse_k = k;
                h1_at = int'(harm_by_1);
                h2_at = int'(harm_by_2);
            end
            step();
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) step();
        vectors++; if (harm_by_1 !== 9'd0) begin miscompares++; $display("FAIL reset_harm1 got %0d want 0", harm_by_1); end
        vectors++; if (harm_by_2 !== 9'd0) begin miscompares++; $display("FAIL reset_harm2 got %0d want 0", harm_by_2); end
        vectors++; if ({end_set_1, end_set_2} !== 2'b00) begin miscompares++; $display("FAIL reset_end_set got %b want 00", {end_set_1, end_set_2}); end
        vectors++; if (charge_level !== 8'd0) begin miscompares++; $display("FAIL reset_charge got %0d want 0", charge_level); end
        vectors++; if (in_flight !== 1'b0) begin miscompares++; $display("FAIL reset_in_flight got %b want 0", in_flight); end
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_hit();
        int chg, fl, pk, n1, n2, both, h1, h2, want;
        run_shot(2'b01, 100, 100, chg, fl, pk, n1, n2, both, h1, h2);
`ifdef ATTACK_CRIT_EN
        want = 84;
`else
        want = 42;
`endif
        exp_h1 = want;
        vectors++; if (chg !== 100) begin miscompares++; $display("FAIL hit_charge got %0d want 100", chg); end
        vectors++; if (fl !== 26) begin miscompares++; $display("FAIL hit_flight_cycles got %0d want 26", fl); end
        vectors++; if (pk + 1 !== 28) begin miscompares++; $display("FAIL hit_pulse_cycle got %0d want 28", pk + 1); end
        vectors++; if (h1 !== want) begin miscompares++; $display("FAIL hit_harm_at_pulse got %0d want %0d", h1, want); end
        vectors++; if (harm_by_1 !== 9'(want)) begin miscompares++; $display("FAIL hit_harm1 got %0d want %0d", harm_by_1, want); end
        vectors++; if (n1 !== 1 || n2 !== 0) begin miscompares++; $display("FAIL hit_pulses got %0d/%0d want 1/0", n1, n2); end
    endtask

    task automatic test_turn_guard();
        int pulses = 0;
        int moved = 0;
        game_turn = 2'b01;
        fire = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (end_set_1 || end_set_2) pulses++;
            if (charge_level !== 8'd100 || in_flight) moved++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL guard_pulses got %0d want 0", pulses); end
        vectors++; if (moved !== 0) begin miscompares++; $display("FAIL guard_recharge got %0d cycles want 0", moved); end
        end_turn();
    endtask

    task automatic test_partial();
        int chg, fl, pk, n1, n2, both, h1, h2;
        run_shot(2'b10, 90, 100, chg, fl, pk, n1, n2, both, h1, h2);
        exp_h2 = 22;
        vectors++; if (harm_by_2 !== 9'd22) begin miscompares++; $display("FAIL partial_harm2 got %0d want 22", harm_by_2); end
        vectors++; if (harm_by_1 !== 9'(exp_h1)) begin miscompares++; $display("FAIL partial_harm1_held got %0d want %0d", harm_by_1, exp_h1); end
        vectors++; if (n2 !== 1 || n1 !== 0) begin miscompares++; $display("FAIL partial_pulses got %0d/%0d want 0/1", n1, n2); end
        vectors++; if (pk !== 24) begin miscompares++; $display("FAIL partial_pulse_k got %0d want 24", pk); end
        end_turn();
    endtask

    task automatic test_miss();
        int chg, fl, pk, n1, n2, both, h1, h2;
        run_shot(2'b01, 50, 100, chg, fl, pk, n1, n2, both, h1, h2);
        exp_h1 = 0;
        vectors++; if (harm_by_1 !== 9'd0) begin miscompares++; $display("FAIL miss_harm1 got %0d want 0", harm_by_1); end
        vectors++; if (harm_by_2 !== 9'(exp_h2)) begin miscompares++; $display("FAIL miss_harm2_held got %0d want %0d", harm_by_2, exp_h2); end
        vectors++; if (n1 !== 1) begin miscompares++; $display("FAIL miss_pulse_count got %0d want 1", n1); end
        end_turn();
    endtask

    task automatic test_saturation();
        int chg, fl, pk, n1, n2, both, h1, h2;
        run_shot(2'b10, 400, 250, chg, fl, pk, n1, n2, both, h1, h2);
        exp_h2 = 32;
        vectors++; if (chg !== 255) begin miscompares++; $display("FAIL sat_charge got %0d want 255", chg); end
        vectors++; if (fl !== 64) begin miscompares++; $display("FAIL sat_flight_cycles got %0d want 64", fl); end
        vectors++; if (pk !== 65) begin miscompares++; $display("FAIL sat_pulse_k got %0d want 65", pk); end
        vectors++; if (harm_by_2 !== 9'd32) begin miscompares++; $display("FAIL sat_harm2 got %0d want 32", harm_by_2); end
        end_turn();
    endtask

    task automatic test_zero_charge();
        int chg, fl, pk, n1, n2, both, h1, h2;
        run_shot(2'b01, 0, 0, chg, fl, pk, n1, n2, both, h1, h2);
        exp_h1 = model_harm(0, 0);
        vectors++; if (chg !== 0) begin miscompares++; $display("FAIL zero_charge got %0d want 0", chg); end
        vectors++; if (fl !== 1) begin miscompares++; $display("FAIL zero_flight_cycles got %0d want 1", fl); end
        vectors++; if (pk !== 2) begin miscompares++; $display("FAIL zero_pulse_k got %0d want 2", pk); end
        vectors++; if (harm_by_1 !== 9'(exp_h1)) begin miscompares++; $display("FAIL zero_harm1 got %0d want %0d", harm_by_1, exp_h1); end
        end_turn();
    endtask

    task automatic test_abort();
        int pulses = 0;
        game_turn = 2'b10;
        target_dist = 8'd80;
        fire = 1'b1;
        repeat (81) step();
        fire = 1'b0;
        step();
        repeat (5) step();
        vectors++; if (in_flight !== 1'b1) begin miscompares++; $display("FAIL abort_pre_flight got %b want 1", in_flight); end
        game_turn = 2'b00;
        step();
        vectors++; if (in_flight !== 1'b0) begin miscompares++; $display("FAIL abort_in_flight got %b want 0", in_flight); end
        fire = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (end_set_1 || end_set_2) pulses++;
        end
        fire = 1'b0;
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        vectors++; if (charge_level !== 8'd80) begin miscompares++; $display("FAIL abort_fire_ignored charge got %0d want 80", charge_level); end
        vectors++; if (harm_by_2 !== 9'(exp_h2)) begin miscompares++; $display("FAIL abort_harm2_held got %0d want %0d", harm_by_2, exp_h2); end
    endtask

    task automatic test_reset_mid_flight();
        int chg, fl, pk, n1, n2, both, h1, h2;
        int pulses = 0;
        game_turn = 2'b01;
        target_dist = 8'd40;
        fire = 1'b1;
        repeat (41) step();
        fire = 1'b0;
        step();
        repeat (3) step();
        #2;
        Reset_n = 1'b0;
        #1;
        exp_h1 = 0;
        exp_h2 = 0;
        vectors++; if (in_flight !== 1'b0) begin miscompares++; $display("FAIL rst_async_in_flight got %b want 0", in_flight); end
        vectors++; if (charge_level !== 8'd0) begin miscompares++; $display("FAIL rst_async_charge got %0d want 0", charge_level); end
        vectors++; if (harm_by_1 !== 9'd0 || harm_by_2 !== 9'd0) begin miscompares++; $display("FAIL rst_async_harm got %0d/%0d want 0/0", harm_by_1, harm_by_2); end
        step();
        step();
        Reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (end_set_1 || end_set_2 || in_flight) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_idle_after got %0d active cycles want 0", pulses); end
        run_shot(2'b01, 60, 60, chg, fl, pk, n1, n2, both, h1, h2);
        exp_h1 = model_harm(60, 60);
        vectors++; if (harm_by_1 !== 9'(exp_h1)) begin miscompares++; $display("FAIL rst_resume_harm1 got %0d want %0d", harm_by_1, exp_h1); end
        end_turn();
    endtask

    task automatic test_random();
        int chg, fl, pk, n1, n2, both, h1, h2;
        int hold, target, want;
        logic [1:0] turn;
        for (int i = 0; i < 10; i++) begin
            turn = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            hold = $urandom_range(0, 150);
            target = hold + $urandom_range(0, 44) - 22;
            if (target < 0) target = 0;
            if (target > 255) target = 255;
            run_shot(turn, hold, target, chg, fl, pk, n1, n2, both, h1, h2);
            want = model_harm(hold, target);
            if (turn == 2'b01) exp_h1 = want; else exp_h2 = want;
            vectors++; if (fl !== (hold / 4) + 1) begin miscompares++; $display("FAIL rnd%0d_flight got %0d want %0d", i, fl, (hold / 4) + 1); end
            vectors++; if (harm_by_1 !== 9'(exp_h1) || harm_by_2 !== 9'(exp_h2)) begin
                miscompares++; $display("FAIL rnd%0d_harm got %0d/%0d want %0d/%0d", i, harm_by_1, harm_by_2, exp_h1, exp_h2);
            end
            vectors++; if (both !== 0 || n1 + n2 !== 1 || (turn == 2'b01 ? n1 : n2) !== 1) begin
                miscompares++; $display("FAIL rnd%0d_pulse got p1=%0d p2=%0d both=%0d want one on shooter", i, n1, n2, both);
            end
            end_turn();
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_turn_guard();
        test_partial();
        test_miss();
        test_saturation();
        test_zero_charge();
        test_abort();
        test_reset_mid_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
